// File: rtl/tt_vpu_ovi_pkg.sv
// rtl/tt_vpu_ovi_pkg.sv - shared load-queue sizing and drain FSM state type
package tt_vpu_ovi_pkg;

    // Number of load-queue entries and the width of an entry index.
    localparam int LQ_DEPTH = 8;
    localparam int LQID_W   = $clog2(LQ_DEPTH);

    // Drain controller states.
    typedef enum logic [1:0] {
        DRAIN_IDLE      = 2'd0,
        DRAIN_WAIT_DATA = 2'd1,
        DRAIN_WRITE     = 2'd2,
        DRAIN_DONE      = 2'd3
    } drain_state_e;

    // Next load-queue entry; wraps naturally through the truncating add.
    function automatic logic [LQID_W-1:0] lqid_next(input logic [LQID_W-1:0] id);
        return id + LQID_W'(1);
    endfunction

endpackage

// File: rtl/tt_load_drain_ctrl_if.sv
// rtl/tt_load_drain_ctrl_if.sv - signal bundle between scoreboard/LQ/VRF side and drain controller
interface tt_load_drain_ctrl_if #(
    parameter  int LQ_DEPTH = tt_vpu_ovi_pkg::LQ_DEPTH,
    localparam int LQID_W   = $clog2(LQ_DEPTH)
);

    // Drain request from the scoreboard.
    logic                drain_req;
    logic [LQID_W-1:0]   drain_ref_count;
    logic [LQID_W-1:0]   drain_lqid_start;
    logic                draining;

    // Per-entry data-return status from the load queue.
    logic [LQ_DEPTH-1:0] lq_data_valid;

    // Writeback towards the VRF write port.
    logic                wb_valid;
    logic [LQID_W-1:0]   wb_lqid;
    logic                wb_ready;

    // Retirement, abort and error status.
    logic                lq_commit;
    logic [LQID_W-1:0]   dest_lqid;
    logic                flush;
    logic                stall_err;

    // Requesting side: scoreboard, load queue, VRF port.
    modport master (
        output drain_req, drain_ref_count, drain_lqid_start,
        output lq_data_valid, wb_ready, flush,
        input  draining, wb_valid, wb_lqid, lq_commit, dest_lqid, stall_err
    );

    // Drain controller side.
    modport slave (
        input  drain_req, drain_ref_count, drain_lqid_start,
        input  lq_data_valid, wb_ready, flush,
        output draining, wb_valid, wb_lqid, lq_commit, dest_lqid, stall_err
    );

endinterface

// File: rtl/tt_load_drain_ctrl.sv
// rtl/tt_load_drain_ctrl.sv - walks a load's LQ entries in order, writing each back and retiring it
module tt_load_drain_ctrl #(
    parameter  int LQ_DEPTH    = tt_vpu_ovi_pkg::LQ_DEPTH,
    parameter  int STALL_LIMIT = 255,
    localparam int LQID_W      = $clog2(LQ_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_drain_req,
    input  logic [LQID_W-1:0]   i_drain_ref_count,
    input  logic [LQID_W-1:0]   i_drain_lqid_start,
    output logic                o_draining,

    input  logic [LQ_DEPTH-1:0] i_lq_data_valid,

    output logic                o_wb_valid,
    output logic [LQID_W-1:0]   o_wb_lqid,
    input  logic                i_wb_ready,

    output logic                o_lq_commit,
    output logic [LQID_W-1:0]   o_dest_lqid,

    input  logic                i_flush,
    output logic                o_stall_err
);

    import tt_vpu_ovi_pkg::*;

    localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    drain_state_e        r_state;
    logic [LQID_W-1:0]   r_ptr;
    logic [LQID_W-1:0]   r_remaining;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_stall_err;

    logic                w_data_ready;
    logic                w_commit;
    logic                w_busy;
    logic                w_stalling;
    logic [STALL_W-1:0]  w_stall_next;

    // Data for the entry under the pointer has come back.
    assign w_data_ready = i_lq_data_valid[r_ptr];

    // A flush in the same cycle suppresses the retirement.
    assign w_commit = (r_state == DRAIN_WRITE) && i_wb_ready && !i_flush;

    // States in which the drain waits on the load queue or the VRF port.
    assign w_busy = (r_state == DRAIN_WAIT_DATA) || (r_state == DRAIN_WRITE);

    // A cycle spent waiting that neither retires an entry nor aborts the drain.
    assign w_stalling = w_busy && !w_commit && !i_flush;

    // Drain FSM: flush wins over every other event, including a new request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= DRAIN_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if (i_flush) begin
            r_state <= DRAIN_IDLE;
        end else begin
            case (r_state)
                DRAIN_IDLE: begin
                    if (i_drain_req) begin
                        r_ptr       <= i_drain_lqid_start;
                        r_remaining <= i_drain_ref_count;
                        r_state     <= (i_drain_ref_count == '0) ? DRAIN_DONE
                                                                 : DRAIN_WAIT_DATA;
                    end
                end
                DRAIN_WAIT_DATA: begin
                    if (w_data_ready) begin
                        r_state <= DRAIN_WRITE;
                    end
                end
                DRAIN_WRITE: begin
                    if (i_wb_ready) begin
                        r_ptr       <= r_ptr + LQID_W'(1);
                        r_remaining <= r_remaining - LQID_W'(1);
                        r_state     <= (r_remaining == LQID_W'(1)) ? DRAIN_DONE
                                                                   : DRAIN_WAIT_DATA;
                    end
                end
                DRAIN_DONE: begin
                    r_state <= DRAIN_IDLE;
                end
                default: begin
                    r_state <= DRAIN_IDLE;
                end
            endcase
        end
    end

    // Next stall count: saturating increment while stalled, otherwise cleared.
    always_comb begin
        w_stall_next = '0;
        if (w_stalling) begin
            w_stall_next = (r_stall_cnt == STALL_MAX) ? r_stall_cnt
                                                      : r_stall_cnt + STALL_W'(1);
        end
    end

    // Stall counter and sticky error flag; only reset clears the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_next;
            if (w_stalling && (w_stall_next == STALL_MAX)) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    // Outputs are decoded from registered state; only the commit pulse
    // follows the ready handshake within the cycle.
    assign o_draining  = (r_state != DRAIN_IDLE);
    assign o_wb_valid  = (r_state == DRAIN_WRITE);
    assign o_wb_lqid   = r_ptr;
    assign o_lq_commit = w_commit;
    assign o_dest_lqid = r_ptr;
    assign o_stall_err = r_stall_err;

endmodule

// File: doc/tt_load_drain_ctrl.md
TT_LOAD_DRAIN_CTRL -- requirements
Module: tt_load_drain_ctrl

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 8: load-queue entries; LQID width = log2(LQ_DEPTH).
REQ-002 SHALL have parameter STALL_LIMIT, default 255: max consecutive cycles waiting on one entry before the error flag sets.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_drain_req  in  1  scoreboard has a load ready to drain.
REQ-006 SHALL have port i_drain_ref_count  in  3  LQ entries owned by that load.
REQ-007 SHALL have port i_drain_lqid_start  in  3  first LQ entry of that load.
REQ-008 SHALL have port o_draining  out  1  drain in progress; blocks scoreboard re-selection.
REQ-009 SHALL have port i_lq_data_valid  in  LQ_DEPTH  per-entry: load data returned.
REQ-010 SHALL have port o_wb_valid  out  1  writeback request for current entry.
REQ-011 SHALL have port o_wb_lqid  out  3  LQ entry being written back.
REQ-012 SHALL have port i_wb_ready  in  1  VRF write port accepts.
REQ-013 SHALL have port o_lq_commit  out  1  one-cycle pulse: entry retired.
REQ-014 SHALL have port o_dest_lqid  out  3  entry retired by o_lq_commit.
REQ-015 SHALL have port i_flush  in  1  abort current drain.
REQ-016 SHALL have port o_stall_err  out  1  sticky stall-limit violation.

Function
REQ-017 SHALL implement FSM IDLE, WAIT_DATA, WRITE, DONE; state register only.
REQ-018 SHALL accept a drain only when state==IDLE && i_drain_req: latch start into ptr and count into remaining.
REQ-019 SHALL drive o_draining = (state != IDLE), registered-state decode, no input combinational path.
REQ-020 SHALL transition IDLE->WAIT_DATA on accept with count>0; IDLE->DONE on accept with count==0.
REQ-021 SHALL transition WAIT_DATA->WRITE when i_lq_data_valid[ptr]==1; otherwise hold.
REQ-022 SHALL assert o_wb_valid only in WRITE, with o_wb_lqid=ptr; o_wb_valid stays asserted, o_wb_lqid stable, until i_wb_ready.
REQ-023 SHALL, on WRITE && i_wb_ready, pulse o_lq_commit the same cycle with o_dest_lqid=ptr, advance ptr by 1 modulo LQ_DEPTH, and decrement remaining.
REQ-024 SHALL, on that handshake, go to DONE if remaining was 1, else WAIT_DATA.
REQ-025 SHALL stay in DONE exactly one cycle, then go to IDLE; a new accept is possible the cycle after DONE.
REQ-026 SHALL wrap ptr 7->0; a start of 6 with count 4 retires entries 6,7,0,1 in that order.
REQ-027 SHALL, on i_flush, go to IDLE next cycle from any state, with no o_lq_commit that cycle.
REQ-028 SHALL give i_flush priority over a simultaneous i_wb_ready and over a simultaneous i_drain_req.
REQ-029 SHALL count consecutive cycles in WAIT_DATA or WRITE without handshake progress, saturating at STALL_LIMIT.
REQ-030 SHALL clear the stall counter on each commit and on leaving those states.
REQ-031 SHALL set o_stall_err when the stall counter reaches STALL_LIMIT; it clears only by reset.
REQ-032 SHALL retire at most one entry per cycle; total commits per drain equal the latched count.

Reset
REQ-033 SHALL, on reset: state=IDLE, ptr=0, remaining=0, stall count=0, o_stall_err=0.
REQ-034 SHALL hold o_draining, o_wb_valid and o_lq_commit at 0 and o_wb_lqid and o_dest_lqid at 0 during reset.
REQ-035 SHALL discard any in-flight drain, issuing no commit, when reset asserts mid-operation.

Structure
REQ-036 SHALL take LQ_DEPTH, LQID_W and the drain FSM state enum from shared package tt_vpu_ovi_pkg.
REQ-037 SHALL be a single module with no sub-modules; ptr arithmetic is truncating LQID_W-bit add.

Verification
REQ-038 SHALL cover: req, start=2, count=3, data valid for all entries, ready=1 -> commits on lqid 2,3,4 on consecutive WRITE handshakes, o_draining high from accept+1 through DONE.
REQ-039 SHALL cover: start=6, count=4 -> o_dest_lqid sequence 6,7,0,1.
REQ-040 SHALL cover: count=0 -> no o_wb_valid, no commit, o_draining high 1 cycle.
REQ-041 SHALL cover: ready low 5 cycles in WRITE -> o_wb_valid held, o_wb_lqid stable, exactly one commit when ready rises.
REQ-042 SHALL cover: i_flush coincident with i_wb_ready -> no commit, IDLE next cycle; and reset mid-drain -> all outputs 0.
REQ-043 SHALL cover: data never valid with STALL_LIMIT=4 -> o_stall_err rises after 4 cycles and stays set after a later flush.
